// File: rtl/prg_pkg.sv
// Shared types and helpers for the program-fetch unit: FSM state, NOP defaults and
// slot extraction from a packed memory word (slot 0 lives in the MSBs).
package prg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  localparam int         SLOT_W     = 16;
  localparam int         MAX_IPW    = 4;
  localparam int         MAX_WORD_W = SLOT_W * MAX_IPW;
  localparam logic [7:0] NOP_IR_DEF = 8'h02;
  localparam logic [7:0] NOP_D_DEF  = 8'h00;

  // word must be left-aligned in MAX_WORD_W bits so slot 0 is always the top 16 bits.
  function automatic logic [SLOT_W-1:0] slot(input logic [MAX_WORD_W-1:0] word,
                                             input logic [1:0]            idx);
    logic [MAX_WORD_W-1:0] sh;
    sh = word << (SLOT_W * int'(idx));
    return sh[MAX_WORD_W-1 -: SLOT_W];
  endfunction

endpackage

// File: rtl/prg_fetch_if.sv
// Program-memory read port of the fetch unit.
interface prg_fetch_if #(
  parameter int PC_W = 16,
  parameter int IPW  = 2
);
  localparam int AW     = PC_W - $clog2(IPW);
  localparam int WORD_W = 16 * IPW;

  // mem_req rises together with mem_addr and both hold until the cycle mem_ack is high;
  // mem_ack is a one-cycle pulse with mem_rdata valid in that cycle; ack without req is ignored.
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/prg_line_buf.sv
// One-word instruction line buffer: stores the last fetched word with its tag,
// reports a hit for the looked-up word address and selects the addressed slot.
module prg_line_buf
  import prg_pkg::*;
#(
  parameter int IPW = 2,
  parameter int AW  = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fill_i,
  input  logic [AW-1:0]       fill_tag_i,
  input  logic [16*IPW-1:0]   fill_data_i,
  input  logic [AW-1:0]       look_tag_i,
  input  logic [1:0]          slot_idx_i,
  output logic                hit_o,
  output logic [SLOT_W-1:0]   slot_o
);
  localparam int WORD_W = SLOT_W * IPW;

  logic [WORD_W-1:0] data_q;
  logic [AW-1:0]     tag_q;
  logic              valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (fill_i) begin
      data_q  <= fill_data_i;
      tag_q   <= fill_tag_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (tag_q == look_tag_i);
  assign slot_o = slot(MAX_WORD_W'(data_q) << (MAX_WORD_W - WORD_W), slot_idx_i);

endmodule

// File: rtl/prg_fetch.sv
// Program-fetch unit: PC with branch loading from BUS/Y, IR/D registers, and a
// req/ack memory port behind a one-word line buffer that bubbles on a miss.
module prg_fetch
  import prg_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              IPW      = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      NOP_IR   = NOP_IR_DEF,
  parameter logic [7:0]      NOP_D    = NOP_D_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DE,
  input  logic               PL,
  input  logic               PH,
  input  logic [7:0]         Y,
  inout  wire  [7:0]         BUS,
  output logic [7:0]         IR,
  output logic [7:0]         D,
  output logic               VALID,
  prg_fetch_if.master        mem,
  output fetch_state_e       dbg_state_o
);
  localparam int SB = $clog2(IPW);
  localparam int AW = PC_W - SB;
  localparam int HW = PC_W - 8;

  fetch_state_e      state_q;
  logic [PC_W-1:0]   pc_q;
  logic [7:0]        ir_q, d_q;
  logic              valid_q;
  logic              req_q;
  logic [AW-1:0]     addr_q;
  logic [7:0]        pend_lo_q;
  logic              pend_lo_v_q;
  logic [HW-1:0]     pend_hi_q;
  logic              pend_hi_v_q;

  logic [AW-1:0]     wa;
  logic [1:0]        slot_idx;
  logic              hit;
  logic              fill;
  logic [SLOT_W-1:0] slot_w;
  logic [PC_W-1:0]   pc_inc, pc_d;
  logic [7:0]        lo_d;
  logic [HW-1:0]     hi_d;

  assign wa       = pc_q[PC_W-1:SB];
  assign slot_idx = 2'(pc_q[1:0] & 2'(IPW - 1));
  assign fill     = (state_q == ST_REQ) && mem.mem_ack;

  prg_line_buf #(.IPW(IPW), .AW(AW)) u_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .fill_i      (fill),
    .fill_tag_i  (addr_q),
    .fill_data_i (mem.mem_rdata),
    .look_tag_i  (wa),
    .slot_idx_i  (slot_idx),
    .hit_o       (hit),
    .slot_o      (slot_w)
  );

  // A branch seen this cycle beats one parked while the previous word was missing.
  always_comb begin
    pc_inc = pc_q + PC_W'(1);
    lo_d   = PL ? BUS : (pend_lo_v_q ? pend_lo_q : pc_inc[7:0]);
    hi_d   = PH ? HW'(Y) : (pend_hi_v_q ? pend_hi_q : pc_inc[PC_W-1:8]);
    pc_d   = {hi_d, lo_d};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= NOP_IR;
      d_q         <= NOP_D;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      pend_lo_q   <= '0;
      pend_lo_v_q <= 1'b0;
      pend_hi_q   <= '0;
      pend_hi_v_q <= 1'b0;
    end else begin
      if (hit) begin
        ir_q        <= slot_w[15:8];
        d_q         <= slot_w[7:0];
        valid_q     <= 1'b1;
        pc_q        <= pc_d;
        pend_lo_v_q <= 1'b0;
        pend_hi_v_q <= 1'b0;
      end else begin
        // pc holds so the delay slot at pc still issues before the branch target.
        ir_q    <= NOP_IR;
        d_q     <= NOP_D;
        valid_q <= 1'b0;
        if (PL) begin
          pend_lo_q   <= BUS;
          pend_lo_v_q <= 1'b1;
        end
        if (PH) begin
          pend_hi_q   <= HW'(Y);
          pend_hi_v_q <= 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: if (!hit) begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
          addr_q  <= wa;
        end
        ST_REQ: if (mem.mem_ack) begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUS          = DE ? d_q : 8'bz;
  assign IR           = ir_q;
  assign D            = d_q;
  assign VALID        = valid_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_prg_fetch.sv
// Bench for prg_fetch: directed scenarios with a latency-configurable memory model;
// issued {bubbles,IR,D} triples are checked against a queue of hand-computed values.
module tb_prg_fetch;
  import prg_pkg::*;

  logic         clk;
  logic         rst;
  logic         de, pl, ph;
  logic [7:0]   y;
  logic         bus_en;
  logic [7:0]   bus_val;
  wire  [7:0]   bus_w;
  logic [7:0]   ir_w, d_w;
  logic         valid_w;
  fetch_state_e dbg_state;

  int           lat;
  logic         mon_en;
  int           checks;
  int           errors;
  logic [23:0]  exp_q[$];

  logic         mem_busy;
  int           mem_cnt;
  logic [14:0]  mem_a;

  prg_fetch_if #(.PC_W(16), .IPW(2)) m ();

  assign bus_w = bus_en ? bus_val : 8'bz;

  prg_fetch #(.PC_W(16), .IPW(2)) dut (
    .CLK         (clk),
    .RST         (rst),
    .DE          (de),
    .PL          (pl),
    .PH          (ph),
    .Y           (y),
    .BUS         (bus_w),
    .IR          (ir_w),
    .D           (d_w),
    .VALID       (valid_w),
    .mem         (m.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory contents and model ----------------
  function automatic logic [15:0] inst(input logic [15:0] p);
    logic [7:0] ir;
    ir = (8'hA1 + p[7:0]) ^ p[15:8];
    return {ir, p[7:0] + 8'h01};
  endfunction

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return {inst({a, 1'b0}), inst({a, 1'b1})};
  endfunction

  // Latches a request when seen and acks it after lat wait cycles, even if req drops.
  initial begin
    m.mem_ack   = 1'b0;
    m.mem_rdata = '0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_a       = '0;
    forever begin
      @(negedge clk);
      m.mem_ack = 1'b0;
      if (!mem_busy && m.mem_req) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_a    = m.mem_addr;
      end
      if (mem_busy) begin
        if (mem_cnt == lat) begin
          m.mem_ack   = 1'b1;
          m.mem_rdata = mem_word(mem_a);
          mem_busy    = 1'b0;
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] bub, input logic [15:0] ir_d);
    exp_q.push_back({bub, ir_d});
  endtask

  task automatic monitor();
    int          bub;
    int          n;
    logic [23:0] e;
    bub = 0;
    n   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mon_en) begin
        bub = 0;
      end else if (valid_w) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: IR=0x%0h D=0x%0h, required no issue", ir_w, d_w);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("issue_%0d {bubbles,IR,D}", n), {8'(bub), ir_w, d_w}, 32'(e));
        end
        n++;
        bub = 0;
      end else begin
        bub++;
      end
    end
  endtask

  task automatic watchdog();
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int new_lat);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b0;
    pl = 1'b0; ph = 1'b0; de = 1'b0; bus_en = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    lat = new_lat;
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_ir(input logic [7:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!(valid_w && ir_w == v) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(valid_w && ir_w == v)) begin
      checks++;
      errors++;
      $display("FAIL wait_ir: IR 0x%0h not seen, last 0x%0h", v, ir_w);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst = 1'b1; de = 1'b0; pl = 1'b0; ph = 1'b0; y = '0;
    bus_en = 1'b0; bus_val = '0; lat = 0; mon_en = 1'b0;
    checks = 0; errors = 0;
    fork
      monitor();
      watchdog();
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_IR", 32'(ir_w), 32'h02);
    check("reset_D", 32'(d_w), 32'h00);
    check("reset_VALID", 32'(valid_w), 32'h0);
    check("reset_mem_req", 32'(m.mem_req), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // sequential fetch, ack in the request cycle; in-word hit keeps mem_req low
    push(8'd2, 16'hA101); push(8'd0, 16'hA202);
    push(8'd2, 16'hA303); push(8'd0, 16'hA404);
    do_reset(0);
    wait_ir(8'hA1);
    check("hit_mem_req_a", 32'(m.mem_req), 32'h0);
    @(negedge clk);
    check("hit_mem_req_b", 32'(m.mem_req), 32'h0);
    drain("seq");

    // PL in a hit cycle redirects right after the current slot
    push(8'd2, 16'hA101); push(8'd0, 16'hA202);
    push(8'd2, 16'hB111); push(8'd0, 16'hB212);
    do_reset(0);
    wait_ir(8'hA1);
    pl = 1'b1; bus_en = 1'b1; bus_val = 8'h10;
    @(negedge clk);
    pl = 1'b0; bus_en = 1'b0;
    drain("hit_branch");

    // PL/PH after 0x0005 issues: delay slot 0x0006 then 0x1240
    push(8'd2, 16'hA101); push(8'd0, 16'hA202); push(8'd2, 16'hA303);
    push(8'd0, 16'hA404); push(8'd2, 16'hA505); push(8'd0, 16'hA606);
    push(8'd2, 16'hA707); push(8'd2, 16'hF341); push(8'd0, 16'hF042);
    do_reset(0);
    wait_ir(8'hA6);
    pl = 1'b1; ph = 1'b1; bus_en = 1'b1; bus_val = 8'h40; y = 8'h12;
    @(negedge clk);
    pl = 1'b0; ph = 1'b0; bus_en = 1'b0;
    drain("branch_far");

    // PL while the first word is outstanding with 3 wait cycles
    push(8'd5, 16'hA101); push(8'd5, 16'h2181);
    push(8'd0, 16'h2282); push(8'd5, 16'h2383);
    do_reset(3);
    @(negedge clk);
    pl = 1'b1; bus_en = 1'b1; bus_val = 8'h80;
    @(negedge clk);
    pl = 1'b0; bus_en = 1'b0;
    drain("miss_branch");

    // reset while a request is outstanding; the late ack must be ignored
    do_reset(1);
    @(negedge clk);
    check("rst_req_high", 32'(m.mem_req), 32'h1);
    check("rst_pc_addr", 32'(m.mem_addr), 32'h0);
    rst = 1'b1; mon_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstack_IR", 32'(ir_w), 32'h02);
    check("rstack_D", 32'(d_w), 32'h00);
    check("rstack_VALID", 32'(valid_w), 32'h0);
    check("rstack_mem_req", 32'(m.mem_req), 32'h0);
    push(8'd3, 16'hA101); push(8'd0, 16'hA202);
    rst = 1'b0; mon_en = 1'b1;
    drain("rst_ack");

    // BUS drive by DE, and PL loading an externally driven BUS value
    push(8'd2, 16'hA101); push(8'd0, 16'hA202); push(8'd2, 16'hFA5A);
    push(8'd2, 16'hFB5B); push(8'd2, 16'hD434);
    do_reset(0);
    wait_ir(8'hA1);
    pl = 1'b1; bus_en = 1'b1; bus_val = 8'h59;
    @(negedge clk);
    pl = 1'b0; bus_en = 1'b0;
    wait_ir(8'hFA);
    de = 1'b1;
    #1;
    check("bus_de_drive", 32'(bus_w), 32'h5A);
    de = 1'b0; bus_en = 1'b1; bus_val = 8'h33;
    #1;
    check("bus_ext_drive", 32'(bus_w), 32'h33);
    pl = 1'b1;
    @(negedge clk);
    pl = 1'b0; bus_en = 1'b0;
    drain("bus");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
